// File: rtl/fifo_access_ctrl_if.sv
// Bus between the FIFO access controller and its producers, consumer and the 8-bit FIFO.
// The controller uses the slave modport. The environment (producers, consumer, FIFO) uses master.
interface fifo_access_ctrl_if #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rd_req;
  logic              rd_ack;
  logic              flush_start;
  logic              flush_done;
  logic              fifo_wr_n;
  logic              fifo_rd_n;
  logic [7:0]        fifo_din;
  logic              fifo_under_flow;
  logic              fifo_over_flow;
  logic [CW-1:0]     occupancy;
  logic              full;
  logic              empty;

  modport master (
    output req_valid, req_data, rd_req, flush_start, fifo_under_flow, fifo_over_flow,
    input  req_ready, rd_ack, flush_done, fifo_wr_n, fifo_rd_n, fifo_din, occupancy, full, empty
  );

  modport slave (
    input  req_valid, req_data, rd_req, flush_start, fifo_under_flow, fifo_over_flow,
    output req_ready, rd_ack, flush_done, fifo_wr_n, fifo_rd_n, fifo_din, occupancy, full, empty
  );
endinterface

// File: rtl/fifo_access_ctrl.sv
// Round-robin write arbiter, read gate and flush sequencer in front of an 8-bit FIFO.
// The optional macro FIFO_ERR_CAPTURE_EN adds sticky underflow/overflow capture and an error-cycle counter.
module fifo_access_ctrl #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  fifo_access_ctrl_if.slave bus
`ifdef FIFO_ERR_CAPTURE_EN
  ,
  output logic              err_uf,
  output logic              err_of,
  output logic [7:0]        err_cnt
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [0:0] {RUN, FLUSH} state_t;

  state_t        state_reg;
  logic [PW-1:0] rr_reg;
  logic [CW-1:0] occ_reg;
  logic [CW-1:0] occ_next;
  logic          wr_n_reg;
  logic          rd_n_reg;
  logic [7:0]    din_reg;
  logic          flush_done_reg;

  logic          full_w;
  logic          empty_w;
  logic          grant_hit;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] cand;
  logic          wr_fire;
  logic          rd_ack_w;
  logic          rd_fire;
  logic [7:0]    grant_data;

  assign full_w  = (occ_reg == CW'(DEPTH));
  assign empty_w = (occ_reg == '0);

  // Scan from farthest to nearest so the last hit is the first valid index after the pointer.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = PW'((int'(rr_reg) + k) % NREQ);
      if (bus.req_valid[cand]) begin
        grant_hit = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign wr_fire    = grant_hit && (state_reg == RUN) && !full_w && !rst;
  assign grant_data = bus.req_data[int'(grant_idx)*8 +: 8];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign bus.req_ready[gi] = wr_fire && (grant_idx == PW'(gi));
    end
  endgenerate

  assign rd_ack_w = (state_reg == RUN) && bus.rd_req && !empty_w && !rst;
  // Drain reads are issued internally; full/empty gating already keeps the count in 0..DEPTH.
  assign rd_fire  = rd_ack_w || ((state_reg == FLUSH) && !empty_w);

  always_comb begin
    occ_next = occ_reg;
    if (wr_fire && !rd_fire)
      occ_next = occ_reg + CW'(1);
    else if (!wr_fire && rd_fire)
      occ_next = occ_reg - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= RUN;
      rr_reg         <= PW'(NREQ - 1);
      occ_reg        <= '0;
      wr_n_reg       <= 1'b1;
      rd_n_reg       <= 1'b1;
      din_reg        <= 8'h00;
      flush_done_reg <= 1'b0;
    end else begin
      occ_reg        <= occ_next;
      wr_n_reg       <= !wr_fire;
      rd_n_reg       <= !rd_fire;
      flush_done_reg <= 1'b0;
      if (wr_fire) begin
        din_reg <= grant_data;
        rr_reg  <= grant_idx;
      end
      case (state_reg)
        RUN:   if (bus.flush_start) state_reg <= FLUSH;
        FLUSH: if (empty_w) begin
                 flush_done_reg <= 1'b1;
                 state_reg      <= RUN;
               end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign bus.rd_ack     = rd_ack_w;
  assign bus.flush_done = flush_done_reg;
  assign bus.fifo_wr_n  = wr_n_reg;
  assign bus.fifo_rd_n  = rd_n_reg;
  assign bus.fifo_din   = din_reg;
  assign bus.occupancy  = occ_reg;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;

`ifdef FIFO_ERR_CAPTURE_EN
  logic       err_uf_reg;
  logic       err_of_reg;
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_uf_reg  <= 1'b0;
      err_of_reg  <= 1'b0;
      err_cnt_reg <= 8'h00;
    end else begin
      if (bus.fifo_under_flow) err_uf_reg <= 1'b1;
      if (bus.fifo_over_flow)  err_of_reg <= 1'b1;
      if ((bus.fifo_under_flow || bus.fifo_over_flow) && (err_cnt_reg != 8'hFF))
        err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_uf  = err_uf_reg;
  assign err_of  = err_of_reg;
  assign err_cnt = err_cnt_reg;
`else
  logic unused_flags;
  assign unused_flags = bus.fifo_under_flow ^ bus.fifo_over_flow;
`endif
endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Scoreboard bench for fifo_access_ctrl: expected FIFO strobes are queued at handshake and popped on wr_n/rd_n.
// Error-capture checks run only when FIFO_ERR_CAPTURE_EN is defined.
module tb_fifo_access_ctrl;
  localparam int NREQ  = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] wq[$];
  bit         rq[$];
  int         rr_m  = NREQ - 1;
  int         occ_m = 0;

  fifo_access_ctrl_if #(.NREQ(NREQ), .DEPTH(DEPTH)) bus ();

`ifdef FIFO_ERR_CAPTURE_EN
  logic       err_uf;
  logic       err_of;
  logic [7:0] err_cnt;
  fifo_access_ctrl #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_uf(err_uf), .err_of(err_of), .err_cnt(err_cnt)
  );
`else
  fifo_access_ctrl #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Strobe scoreboard: each edge's handshake shows up as a low strobe before the following negedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fifo_wr_n === 1'b0) begin
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL wr_strobe: got unexpected wr_n=0 din=%02h, required no write", bus.fifo_din);
        end else begin
          logic [7:0] e;
          e = wq.pop_front();
          if (bus.fifo_din !== e) begin
            bad++;
            $display("FAIL wr_data: got din=%02h, required %02h", bus.fifo_din, e);
          end else
            $display("write  din=%02h ok", bus.fifo_din);
        end
      end else if (wq.size() != 0) begin
        total++; bad++;
        $display("FAIL wr_missing: got wr_n=%b, required 0", bus.fifo_wr_n);
        void'(wq.pop_front());
      end
      if (bus.fifo_rd_n === 1'b0) begin
        total++;
        if (rq.size() == 0) begin
          bad++;
          $display("FAIL rd_strobe: got unexpected rd_n=0, required 1");
        end else begin
          void'(rq.pop_front());
          $display("read   strobe ok");
        end
      end else if (rq.size() != 0) begin
        total++; bad++;
        $display("FAIL rd_missing: got rd_n=%b, required 0", bus.fifo_rd_n);
        void'(rq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One RUN-state cycle: compare handshake outputs with the model, queue expected strobes, advance.
  task automatic drive_cycle(input logic [3:0] valid, input logic rd, input string tag);
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic        exp_ack;
    int          g;
    data = $urandom;
    bus.req_valid = valid;
    bus.req_data  = data;
    bus.rd_req    = rd;
    #1;
    g = -1;
    if (occ_m < DEPTH)
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && valid[(rr_m + k) % NREQ]) g = (rr_m + k) % NREQ;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_ack = rd && (occ_m > 0);
    total += 2;
    if (bus.req_ready !== exp_ready) begin
      bad++;
      $display("FAIL %s req_ready: got %b, required %b", tag, bus.req_ready, exp_ready);
    end
    if (bus.rd_ack !== exp_ack) begin
      bad++;
      $display("FAIL %s rd_ack: got %b, required %b", tag, bus.rd_ack, exp_ack);
    end
    tick();
    bus.req_valid = '0;
    bus.rd_req    = 1'b0;
    if (g >= 0) begin
      wq.push_back(data[g*8 +: 8]);
      rr_m = g;
      occ_m++;
    end
    if (exp_ack) begin
      rq.push_back(1'b1);
      occ_m--;
    end
    total++;
    if (bus.occupancy !== 5'(occ_m) || bus.full !== (occ_m == DEPTH) || bus.empty !== (occ_m == 0)) begin
      bad++;
      $display("FAIL %s occ: got occ=%0d full=%b empty=%b, required occ=%0d", tag,
               bus.occupancy, bus.full, bus.empty, occ_m);
    end
    $display("cycle %s valid=%b rd=%b ready=%b ack=%b occ=%0d", tag, valid, rd, exp_ready, exp_ack, occ_m);
  endtask

  task automatic test_reset();
    bus.req_valid = 4'b1111; bus.req_data = '0; bus.rd_req = 1'b1; bus.flush_start = 1'b0;
    bus.fifo_under_flow = 1'b0; bus.fifo_over_flow = 1'b0;
    repeat (2) tick();
    total++;
    if (bus.fifo_wr_n !== 1'b1 || bus.fifo_rd_n !== 1'b1 || bus.fifo_din !== 8'h00 ||
        bus.occupancy !== 5'd0 || bus.full !== 1'b0 || bus.empty !== 1'b1 ||
        bus.req_ready !== 4'b0000 || bus.rd_ack !== 1'b0 || bus.flush_done !== 1'b0) begin
      bad++;
      $display("FAIL reset: got wr_n=%b rd_n=%b din=%02h occ=%0d full=%b empty=%b ready=%b ack=%b done=%b, required 1 1 00 0 0 1 0000 0 0",
               bus.fifo_wr_n, bus.fifo_rd_n, bus.fifo_din, bus.occupancy, bus.full, bus.empty,
               bus.req_ready, bus.rd_ack, bus.flush_done);
    end
    $display("reset state checked");
    rst = 1'b0; bus.req_valid = '0; bus.rd_req = 1'b0;
    tick();
  endtask

  task automatic test_rr_fairness();
    for (int i = 0; i < 8; i++) drive_cycle(4'b1111, 1'b0, "rr");
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) drive_cycle(4'b0100, 1'b0, "fill");
    total++;
    if (bus.full !== 1'b1) begin
      bad++;
      $display("FAIL full_flag: got %b, required 1", bus.full);
    end
    drive_cycle(4'b1111, 1'b0, "full_nogrant");
    drive_cycle(4'b1111, 1'b1, "full_simul");
    drive_cycle(4'b1111, 1'b0, "full_refill");
    for (int i = 0; i < 10; i++) drive_cycle(4'b0000, 1'b1, "drain");
  endtask

  task automatic test_flush();
    int lows;
    int done_at;
    bus.flush_start = 1'b1;
    tick();
    bus.flush_start = 1'b0; bus.req_valid = 4'b1111; bus.rd_req = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0000 || bus.rd_ack !== 1'b0) begin
      bad++;
      $display("FAIL flush_gate: got ready=%b ack=%b, required 0000 0", bus.req_ready, bus.rd_ack);
    end
    tick();
    for (int i = 0; i < 6; i++) rq.push_back(1'b1);
    lows = 0; done_at = -1;
    for (int c = 0; c < 20 && done_at < 0; c++) begin
      if (bus.flush_done === 1'b1) begin
        done_at = c;
        bus.req_valid = '0; bus.rd_req = 1'b0;
      end else begin
        if (bus.fifo_rd_n === 1'b0) lows++;
        total++;
        if (bus.req_ready !== 4'b0000 || bus.rd_ack !== 1'b0) begin
          bad++;
          $display("FAIL flush_gate_c%0d: got ready=%b ack=%b, required 0000 0", c, bus.req_ready, bus.rd_ack);
        end
        tick();
      end
    end
    occ_m = 0;
    total++;
    if (done_at != 6 || lows != 6) begin
      bad++;
      $display("FAIL flush_seq: got rd_n lows=%0d done_at=%0d, required 6 6", lows, done_at);
    end
    total++;
    if (bus.empty !== 1'b1 || bus.occupancy !== 5'd0) begin
      bad++;
      $display("FAIL flush_empty: got empty=%b occ=%0d, required 1 0", bus.empty, bus.occupancy);
    end
    tick();
    total++;
    if (bus.flush_done !== 1'b0) begin
      bad++;
      $display("FAIL flush_pulse: got flush_done=%b, required 0", bus.flush_done);
    end
    $display("flush lows=%0d done_at=%0d", lows, done_at);
    bus.flush_start = 1'b1;
    tick();
    bus.flush_start = 1'b0;
    tick();
    total++;
    if (bus.flush_done !== 1'b1 || bus.fifo_rd_n !== 1'b1) begin
      bad++;
      $display("FAIL flush_when_empty: got done=%b rd_n=%b, required 1 1", bus.flush_done, bus.fifo_rd_n);
    end
    tick();
  endtask

  task automatic test_empty_simul();
    drive_cycle(4'b0000, 1'b1, "empty_rd");
    for (int i = 0; i < 5; i++) drive_cycle(4'b0001, 1'b0, "to5");
    drive_cycle(4'b0010, 1'b1, "simul5");
  endtask

  task automatic test_reset_midburst();
    drive_cycle(4'b1111, 1'b0, "mid");
    total++;
    if (bus.fifo_wr_n !== 1'b0) begin
      bad++;
      $display("FAIL mid_pre: got wr_n=%b, required 0", bus.fifo_wr_n);
    end
    #1 rst = 1'b1;
    bus.req_valid = 4'b1111; bus.rd_req = 1'b1;
    #1;
    wq.delete(); rq.delete();
    total++;
    if (bus.fifo_wr_n !== 1'b1 || bus.fifo_rd_n !== 1'b1 || bus.occupancy !== 5'd0 ||
        bus.req_ready !== 4'b0000 || bus.rd_ack !== 1'b0 || bus.fifo_din !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset: got wr_n=%b rd_n=%b occ=%0d ready=%b ack=%b din=%02h, required 1 1 0 0000 0 00",
               bus.fifo_wr_n, bus.fifo_rd_n, bus.occupancy, bus.req_ready, bus.rd_ack, bus.fifo_din);
    end
    $display("mid-burst reset checked");
    bus.req_valid = '0; bus.rd_req = 1'b0;
    tick();
    rst = 1'b0; rr_m = NREQ - 1; occ_m = 0;
    drive_cycle(4'b1111, 1'b0, "post_rst");
    tick();
  endtask

`ifdef FIFO_ERR_CAPTURE_EN
  task automatic test_err_capture();
    total++;
    if (err_of !== 1'b0 || err_uf !== 1'b0 || err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL err_reset: got of=%b uf=%b cnt=%0d, required 0 0 0", err_of, err_uf, err_cnt);
    end
    bus.fifo_over_flow = 1'b1;
    repeat (3) tick();
    bus.fifo_over_flow = 1'b0;
    repeat (2) tick();
    total++;
    if (err_of !== 1'b1 || err_uf !== 1'b0 || err_cnt !== 8'd3) begin
      bad++;
      $display("FAIL err_capture: got of=%b uf=%b cnt=%0d, required 1 0 3", err_of, err_uf, err_cnt);
    end
    $display("err capture of=%b cnt=%0d", err_of, err_cnt);
  endtask
`endif

  initial begin
    test_reset();
    test_rr_fairness();
    test_full();
    test_flush();
    test_empty_simul();
    test_reset_midburst();
`ifdef FIFO_ERR_CAPTURE_EN
    test_err_capture();
`endif
    repeat (2) tick();
    total++;
    if (wq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL leftover: got wq=%0d rq=%0d pending, required 0 0", wq.size(), rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
